muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit and HI/LO register owner for the execute stage. It sits beside the single-cycle ALU.
- It accepts MULT/MULTU/DIV/DIVU from decode and runs an iterative shift-add multiply or restoring divide over DATA_WIDTH cycles.
- It stalls the pipeline while busy and holds HI/LO for MFHI/MFLO and MTHI/MTLO.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width; iteration count equals DATA_WIDTH.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
start  in  1  request a new operation; sampled only in IDLE.
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
rsValue  in  DATA_WIDTH  multiplicand or dividend.
rtValue  in  DATA_WIDTH  multiplier or divisor.
flush  in  1  abort the in-flight operation (branch mispredict or exception).
hiWrite  in  1  MTHI, honoured only in IDLE.
loWrite  in  1  MTLO, honoured only in IDLE.
writeData  in  DATA_WIDTH  data for MTHI/MTLO.
busy  out  1  state is neither IDLE nor DONE.
stallRequest  out  1  combinational: busy OR (start AND state==IDLE).
done  out  1  one-cycle pulse; HI/LO hold the new result.
divByZero  out  1  pulses with done when a DIV/DIVU had rtValue==0.
hi  out  DATA_WIDTH  registered HI.
lo  out  DATA_WIDTH  registered LO.

Behaviour:
- Reset (any time, including mid-operation):
  - state=IDLE; hi=lo=0; done=divByZero=busy=0.
  - The iteration counter and internal accumulators are cleared.
- States: IDLE, PREP, ITERATE, FIXUP, DONE.
- IDLE:
  - start=1 latches op, rsValue and rtValue, then goes to PREP.
  - hiWrite/loWrite update hi/lo at the same edge, independent of start.
- PREP:
  - Signed ops: take magnitudes of both operands and record the result sign (rs^rt) and the remainder sign (rs).
  - Clear the counter to 0.
  - Divide with divisor==0 goes to DONE with hi=rsValue, lo=all-ones, divByZero=1.
  - Otherwise go to ITERATE.
- ITERATE: one shift-add or restoring-subtract step per cycle. The counter increments and goes to FIXUP after step DATA_WIDTH-1.
- FIXUP:
  - Signed ops negate the product (2*DATA_WIDTH bits) or quotient per the result sign, and negate the remainder per the dividend sign.
  - Results are written to hi/lo at the edge leaving FIXUP.
- DONE: done=1 for exactly one cycle, then IDLE. start in DONE is ignored; the requester retries in IDLE.
- Latency:
  - start sampled at edge ending cycle 0, so PREP is cycle 1, ITERATE is cycles 2..DATA_WIDTH+1, FIXUP is cycle DATA_WIDTH+2, DONE is cycle DATA_WIDTH+3 (35 for 32-bit).
  - Divide-by-zero reaches DONE at cycle 2.
- Results:
  - MULT/MULTU: {hi,lo} = full 2*DATA_WIDTH product.
  - DIV/DIVU: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - Signed most-negative / -1: lo=0x80000000, hi=0 (no trap).
- start while busy: ignored, no queuing.
- hiWrite/loWrite while busy: ignored.
- flush:
  - In PREP, ITERATE or FIXUP: return to IDLE at the next edge; hi/lo keep their previous values; no done.
  - In DONE: the result is already committed and the done pulse completes.
  - In IDLE together with start: flush wins and start is dropped.
- stallRequest is deasserted in DONE so the issuing instruction advances the cycle the result is visible.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> done at cycle 35, hi=0xFFFFFFFE lo=0x00000001, stallRequest high cycles 0..34.
- MULT rs=-3 rt=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1. DIV rs=-7 rt=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. DIV rs=0x80000000 rt=0xFFFFFFFF -> lo=0x80000000 hi=0.
- DIVU rs=100 rt=7 -> lo=14 hi=2. DIVU rs=5 rt=0 -> done and divByZero at cycle 2, hi=5 lo=0xFFFFFFFF.
- Preload MTHI 0x11 and MTLO 0x22. Start MULTU 6*7, flush at cycle 10 -> busy drops at cycle 11, no done, hi=0x11 lo=0x22. Then start MULTU 6*7 again -> lo=42 hi=0.
- Start MULT, assert start again plus hiWrite at cycle 5 -> both ignored, single done at cycle 35 with the first result.
- Drive reset low at cycle 20 of a DIVU -> immediately state IDLE, hi=lo=0, busy=0. Release reset and start DIVU 9/3 -> lo=3 hi=0 with full latency.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bus between the execute stage and the multiply/divide
// sequencer. The stage drives the master side; the sequencer is the slave.
interface muldiv_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] rsValue;
  logic [DATA_WIDTH-1:0] rtValue;
  logic                  flush;
  logic                  hiWrite;
  logic                  loWrite;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  busy;
  logic                  stallRequest;
  logic                  done;
  logic                  divByZero;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output start, op, rsValue, rtValue, flush, hiWrite, loWrite, writeData,
    input  busy, stallRequest, done, divByZero, hi, lo
  );

  modport slave (
    input  start, op, rsValue, rtValue, flush, hiWrite, loWrite, writeData,
    output busy, stallRequest, done, divByZero, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit that owns HI/LO. Multiplies use shift-add,
// divides use restoring subtraction, one bit per cycle over DATA_WIDTH steps.
// Signed operations run on magnitudes and fix the signs up at the end.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input logic               clock,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);

  localparam int            CW        = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITERATE,
    FIXUP,
    DONE
  } state_t;

  state_t state_q, next_state;

  // Latched request and iteration state.
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] rs_q, rt_q;
  logic [DATA_WIDTH-1:0] operand_q;  // multiplicand or divisor magnitude
  logic [DATA_WIDTH-1:0] upper_q;    // product high half / partial remainder
  logic [DATA_WIDTH-1:0] lower_q;    // multiplier bits / dividend-quotient
  logic [CW-1:0]         count_q;
  logic                  res_neg_q, rem_neg_q, dbz_q;
  logic [DATA_WIDTH-1:0] hi_q, lo_q;

  // FSM strobes into the datapath.
  logic accept, prep_load, prep_dbz, step, commit;

  // op[1] selects divide, op[0] selects the unsigned variant.
  logic is_div, is_signed;
  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

  // Operand magnitudes; the most-negative value maps onto itself, which is
  // the correct unsigned magnitude.
  logic                  rs_neg, rt_neg;
  logic [DATA_WIDTH-1:0] rs_mag, rt_mag;
  assign rs_neg = is_signed & rs_q[DATA_WIDTH-1];
  assign rt_neg = is_signed & rt_q[DATA_WIDTH-1];
  assign rs_mag = rs_neg ? -rs_q : rs_q;
  assign rt_mag = rt_neg ? -rt_q : rt_q;

  // Shift-add step: add the multiplicand when the current multiplier bit is
  // set, keeping the carry so the right shift brings it into the high half.
  logic [DATA_WIDTH-1:0] addend;
  logic [DATA_WIDTH:0]   mul_sum;
  assign addend  = lower_q[0] ? operand_q : '0;
  assign mul_sum = {1'b0, upper_q} + {1'b0, addend};

  // Restoring step: shift the next dividend bit into the remainder and try
  // the subtraction. The partial remainder stays below the divisor, so the
  // top bit of the difference is a clean borrow flag.
  logic [DATA_WIDTH:0] div_diff;
  logic                div_fits;
  assign div_diff = {upper_q, lower_q[DATA_WIDTH-1]} - {1'b0, operand_q};
  assign div_fits = ~div_diff[DATA_WIDTH];

  // Sign fix-up of the finished magnitudes.
  logic [2*DATA_WIDTH-1:0] product, product_fix;
  logic [DATA_WIDTH-1:0]   quot_fix, rem_fix;
  assign product     = {upper_q, lower_q};
  assign product_fix = res_neg_q ? -product : product;
  assign quot_fix    = res_neg_q ? -lower_q : lower_q;
  assign rem_fix     = rem_neg_q ? -upper_q : upper_q;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= next_state;
  end

  // Next-state decode and datapath strobes; flush preempts any work in flight.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    next_state = state_q;
    accept     = 1'b0;
    prep_load  = 1'b0;
    prep_dbz   = 1'b0;
    step       = 1'b0;
    commit     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          accept     = 1'b1;
          next_state = PREP;
        end
      end
      PREP: begin
        if (bus.flush) begin
          next_state = IDLE;
        end else if (is_div && (rt_q == '0)) begin
          prep_dbz   = 1'b1;
          next_state = DONE;
        end else begin
          prep_load  = 1'b1;
          next_state = ITERATE;
        end
      end
      ITERATE: begin
        if (bus.flush) begin
          next_state = IDLE;
        end else begin
          step = 1'b1;
          if (count_q == LAST_STEP) next_state = FIXUP;
        end
      end
      FIXUP: begin
        if (bus.flush) begin
          next_state = IDLE;
        end else begin
          commit     = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch, operand preparation and per-cycle iteration.
  // NOTE: the accumulators are plain flops, so they are cleared on reset to
  // keep an aborted operation from leaving stale state behind.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      operand_q <= '0;
      upper_q   <= '0;
      lower_q   <= '0;
      count_q   <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= bus.op;
        rs_q  <= bus.rsValue;
        rt_q  <= bus.rtValue;
        dbz_q <= 1'b0;
      end
      if (prep_load || prep_dbz) count_q <= '0;
      if (prep_dbz) dbz_q <= 1'b1;
      if (prep_load) begin
        upper_q   <= '0;
        res_neg_q <= rs_neg ^ rt_neg;
        rem_neg_q <= rs_neg;
        if (is_div) begin
          lower_q   <= rs_mag;
          operand_q <= rt_mag;
        end else begin
          lower_q   <= rt_mag;
          operand_q <= rs_mag;
        end
      end
      if (step) begin
        count_q <= count_q + CW'(1);
        if (is_div) begin
          upper_q <= div_fits ? div_diff[DATA_WIDTH-1:0]
                              : {upper_q[DATA_WIDTH-2:0], lower_q[DATA_WIDTH-1]};
          lower_q <= {lower_q[DATA_WIDTH-2:0], div_fits};
        end else begin
          upper_q <= mul_sum[DATA_WIDTH:1];
          lower_q <= {mul_sum[0], lower_q[DATA_WIDTH-1:1]};
        end
      end
    end
  end

  // HI/LO: MTHI/MTLO only while idle; results land when leaving PREP
  // (divide by zero) or FIXUP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (state_q == IDLE && bus.hiWrite) hi_q <= bus.writeData;
      if (state_q == IDLE && bus.loWrite) lo_q <= bus.writeData;
      if (prep_dbz) begin
        hi_q <= rs_q;
        lo_q <= '1;
      end
      if (commit) begin
        if (is_div) begin
          hi_q <= rem_fix;
          lo_q <= quot_fix;
        end else begin
          {hi_q, lo_q} <= product_fix;
        end
      end
    end
  end

  assign bus.busy         = (state_q != IDLE) && (state_q != DONE);
  assign bus.stallRequest = bus.busy || (bus.start && (state_q == IDLE));
  assign bus.done         = (state_q == DONE);
  assign bus.divByZero    = (state_q == DONE) && dbz_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed products, quotients,
// latencies, flush, ignored requests and asynchronous reset mid-operation.
module tb_muldiv_sequencer;

  localparam int         W        = 32;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  muldiv_sequencer_if #(.DATA_WIDTH(W)) bus ();

  muldiv_sequencer #(.DATA_WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Issue at the current cycle (cycle 0) and watch until done, sampling at
  // negedges. Returns the done cycle (-1 on timeout), the divByZero flag,
  // how many cycles stallRequest was high before done and its value at done.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] rs,
                        input logic [W-1:0] rt, output int cyc,
                        output logic dbz, output int stall_cnt,
                        output logic stall_at_done);
    bus.start = 1'b1; bus.op = op; bus.rsValue = rs; bus.rtValue = rt;
    cyc = -1; dbz = 1'b0; stall_cnt = 0; stall_at_done = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (bus.done) begin
        cyc = c; dbz = bus.divByZero; stall_at_done = bus.stallRequest;
        break;
      end
      if (bus.stallRequest) stall_cnt++;
      @(posedge clock); #1;
      bus.start = 1'b0;
    end
  endtask

  task automatic do_op(input string name, input logic [1:0] op,
                       input logic [W-1:0] rs, input logic [W-1:0] rt,
                       input int exp_cyc, input logic exp_dbz,
                       input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int   cyc, stall_cnt;
    logic dbz, stall_at_done;
    run_op(op, rs, rt, cyc, dbz, stall_cnt, stall_at_done);
    check({name, "_done_cycle"}, cyc, exp_cyc);
    check({name, "_hi"}, bus.hi, exp_hi);
    check({name, "_lo"}, bus.lo, exp_lo);
    check({name, "_divbyzero"}, dbz, exp_dbz);
    check({name, "_stall_cycles"}, stall_cnt, exp_cyc);
    check({name, "_stall_at_done"}, stall_at_done, 1'b0);
    @(posedge clock); #1;
    check({name, "_done_one_cycle"}, bus.done, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   done_cnt, done_cyc;
    logic busy10, busy11, hi_mid;
    logic [W-1:0] hi_at, lo_at;

    reset = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.rsValue = '0; bus.rtValue = '0;
    bus.flush = 1'b0; bus.hiWrite = 1'b0; bus.loWrite = 1'b0; bus.writeData = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_hi", bus.hi, 0);
    check("reset_lo", bus.lo, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_stall", bus.stallRequest, 0);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;

    // Multiplies.
    do_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 35, 1'b0,
          32'hFFFFFFFE, 32'h00000001);
    do_op("mult_m3x5", OP_MULT, 32'hFFFFFFFD, 32'd5, 35, 1'b0,
          32'hFFFFFFFF, 32'hFFFFFFF1);
    do_op("mult_m4xm6", OP_MULT, 32'hFFFFFFFC, 32'hFFFFFFFA, 35, 1'b0,
          32'h0, 32'd24);

    // Divides.
    do_op("div_m7d2", OP_DIV, 32'hFFFFFFF9, 32'd2, 35, 1'b0,
          32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("div_7dm2", OP_DIV, 32'd7, 32'hFFFFFFFE, 35, 1'b0,
          32'h1, 32'hFFFFFFFD);
    do_op("div_minneg", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 35, 1'b0,
          32'h0, 32'h80000000);
    do_op("divu_100d7", OP_DIVU, 32'd100, 32'd7, 35, 1'b0, 32'd2, 32'd14);
    do_op("divu_by0", OP_DIVU, 32'd5, 32'd0, 2, 1'b1, 32'd5, 32'hFFFFFFFF);

    // MTHI / MTLO while idle.
    bus.hiWrite = 1'b1; bus.writeData = 32'h11;
    @(posedge clock); #1;
    bus.hiWrite = 1'b0; bus.loWrite = 1'b1; bus.writeData = 32'h22;
    @(posedge clock); #1;
    bus.loWrite = 1'b0;
    check("mthi", bus.hi, 32'h11);
    check("mtlo", bus.lo, 32'h22);

    // Flush mid-iteration: no done, HI/LO untouched.
    bus.start = 1'b1; bus.op = OP_MULTU; bus.rsValue = 32'd6; bus.rtValue = 32'd7;
    done_cnt = 0; busy10 = 1'b0; busy11 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == 1)  bus.start = 1'b0;
      if (c == 10) bus.flush = 1'b1;
      if (c == 11) bus.flush = 1'b0;
      @(negedge clock);
      if (bus.done) done_cnt++;
      if (c == 10) busy10 = bus.busy;
      if (c == 11) busy11 = bus.busy;
      @(posedge clock); #1;
    end
    check("flush_busy_c10", busy10, 1'b1);
    check("flush_busy_c11", busy11, 1'b0);
    check("flush_no_done", done_cnt, 0);
    check("flush_hi_kept", bus.hi, 32'h11);
    check("flush_lo_kept", bus.lo, 32'h22);

    // Flush together with start while idle: start dropped.
    bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_idle_start_dropped", bus.busy, 1'b0);

    do_op("multu_after_flush", OP_MULTU, 32'd6, 32'd7, 35, 1'b0, 32'h0, 32'd42);

    // start and MTHI while busy are ignored.
    bus.start = 1'b1; bus.op = OP_MULT; bus.rsValue = 32'd7; bus.rtValue = 32'hFFFFFFFE;
    done_cnt = 0; done_cyc = -1; hi_mid = 1'b1; hi_at = '0; lo_at = '0;
    for (int c = 0; c < 45; c++) begin
      if (c == 1) bus.start = 1'b0;
      if (c == 5) begin
        bus.start = 1'b1; bus.op = OP_MULTU; bus.rsValue = 32'd2; bus.rtValue = 32'd3;
        bus.hiWrite = 1'b1; bus.writeData = 32'hDEAD;
      end
      if (c == 6) begin bus.start = 1'b0; bus.hiWrite = 1'b0; end
      @(negedge clock);
      if (c == 6) hi_mid = (bus.hi == 32'h0);
      if (bus.done) begin
        done_cnt++; done_cyc = c; hi_at = bus.hi; lo_at = bus.lo;
      end
      @(posedge clock); #1;
    end
    check("busy_mthi_ignored", hi_mid, 1'b1);
    check("busy_single_done", done_cnt, 1);
    check("busy_done_cycle", done_cyc, 35);
    check("busy_first_hi", hi_at, 32'hFFFFFFFF);
    check("busy_first_lo", lo_at, 32'hFFFFFFF2);

    // Asynchronous reset partway through a divide.
    bus.start = 1'b1; bus.op = OP_DIVU; bus.rsValue = 32'd1000; bus.rtValue = 32'd10;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      bus.start = 1'b0;
    end
    check("pre_reset_busy", bus.busy, 1'b1);
    reset = 1'b0;
    #1;
    check("async_reset_hi", bus.hi, 0);
    check("async_reset_lo", bus.lo, 0);
    check("async_reset_busy", bus.busy, 0);
    check("async_reset_done", bus.done, 0);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    do_op("divu_9d3_after_reset", OP_DIVU, 32'd9, 32'd3, 35, 1'b0, 32'h0, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
